// File: rtl/ime_mv_ram_arb_if.sv
// rtl/ime_mv_ram_arb_if.sv - requester-side bundle of the IME MV RAM arbiter
//
// Purpose : groups the IME writer and the two readers (FME rd0, MVP rd1)
//           with their acks and the tagged read-return path.
// Modports: master - requester side (drives req/adr/dat, sees ack/vld/data)
//           slave  - arbiter side
interface ime_mv_ram_arb_if;
    logic        wr_req_i;
    logic [5:0]  wr_adr_i;
    logic [12:0] wr_dat_i;
    logic        wr_ack_o;

    logic        rd0_req_i;
    logic [5:0]  rd0_adr_i;
    logic        rd0_ack_o;
    logic        rd0_vld_o;

    logic        rd1_req_i;
    logic [5:0]  rd1_adr_i;
    logic        rd1_ack_o;
    logic        rd1_vld_o;

    logic [12:0] rd_dat_o;

    modport master (
        output wr_req_i, wr_adr_i, wr_dat_i,
        output rd0_req_i, rd0_adr_i, rd1_req_i, rd1_adr_i,
        input  wr_ack_o, rd0_ack_o, rd1_ack_o, rd0_vld_o, rd1_vld_o, rd_dat_o
    );

    modport slave (
        input  wr_req_i, wr_adr_i, wr_dat_i,
        input  rd0_req_i, rd0_adr_i, rd1_req_i, rd1_adr_i,
        output wr_ack_o, rd0_ack_o, rd1_ack_o, rd0_vld_o, rd1_vld_o, rd_dat_o
    );
endinterface

// File: rtl/ime_mv_ram_arb.sv
// rtl/ime_mv_ram_arb.sv - single-cycle arbiter for the 64x13 IME MV RAM
//
// Purpose : grants at most one of {IME write, FME read rd0, MVP read rd1}
//           per cycle onto the single-port RAM and tags the read data that
//           comes back one cycle later with the requester that issued it.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           req_if (slave)      - requester handshakes and read return
//           ram_adr_o           - RAM address (0 when idle)
//           ram_wr_ena_o        - RAM write enable, low active
//           ram_wr_dat_o        - RAM write data (0 unless writing)
//           ram_rd_ena_o        - RAM read enable, low active
//           ram_rd_dat_i        - RAM read data, valid one cycle after read
module ime_mv_ram_arb #(
    parameter int WR_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    ime_mv_ram_arb_if.slave   req_if,
    output logic [5:0]        ram_adr_o,
    output logic              ram_wr_ena_o,
    output logic [12:0]       ram_wr_dat_o,
    output logic              ram_rd_ena_o,
    input  logic [12:0]       ram_rd_dat_i
);

    localparam logic [3:0] WCNT_MAX = 4'(WR_BURST_MAX);

    logic [3:0] wcnt_q, wcnt_d;
    logic       rr_q, rr_d;
    logic       rd0_vld_q, rd1_vld_q;

    logic       rd_pend;
    logic       wr_hold_off;
    logic       gnt_wr, gnt_rd0, gnt_rd1;

    // Grant decode. Reset masks every grant so the RAM stays untouched.
    always_comb begin
        rd_pend     = req_if.rd0_req_i | req_if.rd1_req_i;
        // Writes yield only once the burst budget is spent and a reader waits.
        wr_hold_off = (wcnt_q == WCNT_MAX) && rd_pend;
        gnt_wr      = !rst && req_if.wr_req_i && !wr_hold_off;
        // A lone reader wins outright; rr only breaks a tie.
        gnt_rd0     = !rst && !gnt_wr && req_if.rd0_req_i &&
                      (!req_if.rd1_req_i || !rr_q);
        gnt_rd1     = !rst && !gnt_wr && req_if.rd1_req_i &&
                      (!req_if.rd0_req_i || rr_q);
    end

    always_comb begin
        wcnt_d = wcnt_q;
        rr_d   = rr_q;
        if (gnt_rd0 || gnt_rd1) begin
            wcnt_d = 4'd0;
        end else if (!rd_pend) begin
            wcnt_d = 4'd0;
        end else if (gnt_wr && (wcnt_q < WCNT_MAX)) begin
            wcnt_d = wcnt_q + 4'd1;
        end
        if (gnt_rd0) begin
            rr_d = 1'b1;
        end else if (gnt_rd1) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q    <= 4'd0;
            rr_q      <= 1'b0;
            rd0_vld_q <= 1'b0;
            rd1_vld_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            rr_q      <= rr_d;
            rd0_vld_q <= gnt_rd0;
            rd1_vld_q <= gnt_rd1;
        end
    end

    always_comb begin
        ram_adr_o    = 6'd0;
        ram_wr_dat_o = 13'd0;
        ram_wr_ena_o = 1'b1;
        ram_rd_ena_o = 1'b1;
        if (gnt_wr) begin
            ram_adr_o    = req_if.wr_adr_i;
            ram_wr_dat_o = req_if.wr_dat_i;
            ram_wr_ena_o = 1'b0;
        end else if (gnt_rd0) begin
            ram_adr_o    = req_if.rd0_adr_i;
            ram_rd_ena_o = 1'b0;
        end else if (gnt_rd1) begin
            ram_adr_o    = req_if.rd1_adr_i;
            ram_rd_ena_o = 1'b0;
        end
    end

    assign req_if.wr_ack_o  = gnt_wr;
    assign req_if.rd0_ack_o = gnt_rd0;
    assign req_if.rd1_ack_o = gnt_rd1;
    // The tag from a read granted just before reset must not leak out while
    // reset is held, so the registered tags are masked by rst.
    assign req_if.rd0_vld_o = rd0_vld_q && !rst;
    assign req_if.rd1_vld_o = rd1_vld_q && !rst;
    assign req_if.rd_dat_o  = ram_rd_dat_i;

endmodule

// File: tb/tb_ime_mv_ram_arb.sv
// tb/tb_ime_mv_ram_arb.sv - self-checking bench for ime_mv_ram_arb
module tb_ime_mv_ram_arb;
    localparam int WBM = 4;

    logic        clk;
    logic        rst;
    logic [5:0]  ram_adr;
    logic        ram_wr_ena;
    logic [12:0] ram_wr_dat;
    logic        ram_rd_ena;
    logic [12:0] ram_rd_dat;

    int checks = 0;
    int errors = 0;

    ime_mv_ram_arb_if bus ();

    ime_mv_ram_arb #(.WR_BURST_MAX(WBM)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_if       (bus.slave),
        .ram_adr_o    (ram_adr),
        .ram_wr_ena_o (ram_wr_ena),
        .ram_wr_dat_o (ram_wr_dat),
        .ram_rd_ena_o (ram_rd_ena),
        .ram_rd_dat_i (ram_rd_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 64x13 single-port RAM with registered read
    logic [12:0] mem [64];
    logic [12:0] ref_mem [64];
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 13'd0;
            ref_mem[i] = 13'd0;
        end
        ram_rd_dat = 13'd0;
    end
    always @(posedge clk) begin
        if (!ram_wr_ena) mem[ram_adr] <= ram_wr_dat;
        if (!ram_rd_ena) ram_rd_dat <= mem[ram_adr];
    end

    // Scoreboard: expected read data pushed at grant, popped at vld
    logic [12:0] q0 [$];
    logic [12:0] q1 [$];
    always @(negedge clk) begin
        logic [12:0] e;
        checks++;
        if (!ram_wr_ena && !ram_rd_ena) begin
            errors++;
            $display("FAIL ena_excl: wr_ena=%b rd_ena=%b expected not both 0", ram_wr_ena, ram_rd_ena);
        end
        checks++;
        if ((32'(bus.wr_ack_o) + 32'(bus.rd0_ack_o) + 32'(bus.rd1_ack_o)) > 1) begin
            errors++;
            $display("FAIL ack_onehot: acks=%b%b%b expected at most one", bus.wr_ack_o, bus.rd0_ack_o, bus.rd1_ack_o);
        end
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (bus.rd0_vld_o) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL rd0_vld_spurious: vld=1 expected 0");
                end else begin
                    e = q0.pop_front();
                    if (bus.rd_dat_o !== e) begin
                        errors++;
                        $display("FAIL rd0_data: got %h expected %h", bus.rd_dat_o, e);
                    end
                end
            end
            if (bus.rd1_vld_o) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL rd1_vld_spurious: vld=1 expected 0");
                end else begin
                    e = q1.pop_front();
                    if (bus.rd_dat_o !== e) begin
                        errors++;
                        $display("FAIL rd1_data: got %h expected %h", bus.rd_dat_o, e);
                    end
                end
            end
            if (bus.rd0_ack_o) q0.push_back(ref_mem[bus.rd0_adr_i]);
            if (bus.rd1_ack_o) q1.push_back(ref_mem[bus.rd1_adr_i]);
            if (bus.wr_ack_o)  ref_mem[bus.wr_adr_i] = bus.wr_dat_i;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.wr_req_i  = 1'b0;
        bus.wr_adr_i  = 6'd0;
        bus.wr_dat_i  = 13'd0;
        bus.rd0_req_i = 1'b0;
        bus.rd0_adr_i = 6'd0;
        bus.rd1_req_i = 1'b0;
        bus.rd1_adr_i = 6'd0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        adv();
        adv();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_req_i  = 1'b1;
            bus.wr_adr_i  = 6'(i + 1);
            bus.wr_dat_i  = 13'h1FFF;
            bus.rd0_req_i = 1'b1;
            bus.rd0_adr_i = 6'd3;
            bus.rd1_req_i = 1'b1;
            bus.rd1_adr_i = 6'd4;
            @(negedge clk);
            checks++;
            if ({bus.wr_ack_o, bus.rd0_ack_o, bus.rd1_ack_o, bus.rd0_vld_o, bus.rd1_vld_o, ram_wr_ena, ram_rd_ena} !== 7'b0000011) begin
                errors++;
                $display("FAIL reset_hold: acks/vld/ena=%b expected 0000011",
                         {bus.wr_ack_o, bus.rd0_ack_o, bus.rd1_ack_o, bus.rd0_vld_o, bus.rd1_vld_o, ram_wr_ena, ram_rd_ena});
            end
            adv();
        end
        rst = 1'b0;
        clear_reqs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.wr_ack_o, bus.rd0_ack_o, bus.rd1_ack_o, bus.rd0_vld_o, bus.rd1_vld_o, ram_wr_ena, ram_rd_ena, ram_adr, ram_wr_dat} !==
                {7'b0000011, 6'd0, 13'd0}) begin
                errors++;
                $display("FAIL idle: acks/vld/ena=%b adr=%h wdat=%h expected 0000011 0 0",
                         {bus.wr_ack_o, bus.rd0_ack_o, bus.rd1_ack_o, bus.rd0_vld_o, bus.rd1_vld_o, ram_wr_ena, ram_rd_ena}, ram_adr, ram_wr_dat);
            end
            adv();
        end
    endtask

    task automatic test_write_read();
        do_reset();
        bus.wr_req_i = 1'b1;
        bus.wr_adr_i = 6'd5;
        bus.wr_dat_i = 13'h1ABC;
        @(negedge clk);
        checks++;
        if ({bus.wr_ack_o, ram_wr_ena, ram_rd_ena, ram_adr, ram_wr_dat} !== {3'b101, 6'd5, 13'h1ABC}) begin
            errors++;
            $display("FAIL wr_grant: ack/wena/rena=%b adr=%h wdat=%h expected 101 05 1abc",
                     {bus.wr_ack_o, ram_wr_ena, ram_rd_ena}, ram_adr, ram_wr_dat);
        end
        adv();
        clear_reqs();
        bus.rd0_req_i = 1'b1;
        bus.rd0_adr_i = 6'd5;
        @(negedge clk);
        checks++;
        if ({bus.rd0_ack_o, bus.wr_ack_o, ram_wr_ena, ram_rd_ena, ram_adr} !== {4'b1010, 6'd5}) begin
            errors++;
            $display("FAIL rd0_grant: ack0/ackw/wena/rena=%b adr=%h expected 1010 05",
                     {bus.rd0_ack_o, bus.wr_ack_o, ram_wr_ena, ram_rd_ena}, ram_adr);
        end
        adv();
        clear_reqs();
        @(negedge clk);
        checks++;
        if ({bus.rd0_vld_o, bus.rd1_vld_o, bus.rd_dat_o} !== {2'b10, 13'h1ABC}) begin
            errors++;
            $display("FAIL raw_readback: vld=%b%b dat=%h expected 10 1abc", bus.rd0_vld_o, bus.rd1_vld_o, bus.rd_dat_o);
        end
        adv();
    endtask

    task automatic test_alternate();
        clear_reqs();
        bus.wr_req_i = 1'b1;
        bus.wr_adr_i = 6'd10;
        bus.wr_dat_i = 13'h0AAA;
        adv();
        bus.wr_adr_i = 6'd20;
        bus.wr_dat_i = 13'h1555;
        adv();
        do_reset();
        bus.rd0_req_i = 1'b1;
        bus.rd0_adr_i = 6'd10;
        bus.rd1_req_i = 1'b1;
        bus.rd1_adr_i = 6'd20;
        for (int i = 0; i < 6; i++) begin
            logic       e0;
            logic [1:0] ev;
            logic [5:0] ea;
            e0 = (i % 2) == 0;
            ea = e0 ? 6'd10 : 6'd20;
            ev = (i == 0) ? 2'b00 : (e0 ? 2'b01 : 2'b10);
            @(negedge clk);
            checks++;
            if ({bus.rd0_ack_o, bus.rd1_ack_o, bus.rd0_vld_o, bus.rd1_vld_o, ram_adr} !== {e0, !e0, ev, ea}) begin
                errors++;
                $display("FAIL alternate[%0d]: ack=%b%b vld=%b%b adr=%h expected ack=%b%b vld=%b adr=%h",
                         i, bus.rd0_ack_o, bus.rd1_ack_o, bus.rd0_vld_o, bus.rd1_vld_o, ram_adr, e0, !e0, ev, ea);
            end
            adv();
        end
        clear_reqs();
        @(negedge clk);
        checks++;
        if ({bus.rd0_vld_o, bus.rd1_vld_o, bus.rd_dat_o} !== {2'b01, 13'h1555}) begin
            errors++;
            $display("FAIL alternate_tail: vld=%b%b dat=%h expected 01 1555", bus.rd0_vld_o, bus.rd1_vld_o, bus.rd_dat_o);
        end
        adv();
    endtask

    task automatic test_burst();
        do_reset();
        bus.wr_req_i  = 1'b1;
        bus.wr_adr_i  = 6'd30;
        bus.rd1_req_i = 1'b1;
        bus.rd1_adr_i = 6'd30;
        for (int i = 0; i < 10; i++) begin
            logic ew;
            ew = (i % 5) != 4;
            bus.wr_dat_i = 13'(16'h0100 + i);
            @(negedge clk);
            checks++;
            if ({bus.wr_ack_o, bus.rd0_ack_o, bus.rd1_ack_o} !== {ew, 1'b0, !ew}) begin
                errors++;
                $display("FAIL burst[%0d]: acks(w,r0,r1)=%b%b%b expected %b0%b",
                         i, bus.wr_ack_o, bus.rd0_ack_o, bus.rd1_ack_o, ew, !ew);
            end
            adv();
        end
        clear_reqs();
        adv();
    endtask

    task automatic test_reset_drop();
        do_reset();
        bus.rd1_req_i = 1'b1;
        bus.rd1_adr_i = 6'd7;
        @(negedge clk);
        checks++;
        if (bus.rd1_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_grant: rd1_ack=%b expected 1", bus.rd1_ack_o);
        end
        adv();
        clear_reqs();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rd1_vld_o, bus.rd1_ack_o} !== 2'b00) begin
            errors++;
            $display("FAIL drop_in_reset: vld/ack=%b%b expected 00", bus.rd1_vld_o, bus.rd1_ack_o);
        end
        adv();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rd1_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_after_reset: rd1_vld=%b expected 0", bus.rd1_vld_o);
        end
        adv();
        // Leave rr pointing at rd1, then reset: the tie must go to rd0
        bus.rd0_req_i = 1'b1;
        adv();
        bus.rd0_req_i = 1'b0;
        rst = 1'b1;
        adv();
        rst = 1'b0;
        bus.rd0_req_i = 1'b1;
        bus.rd1_req_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rd0_ack_o, bus.rd1_ack_o} !== 2'b10) begin
            errors++;
            $display("FAIL rr_reset: ack=%b%b expected 10", bus.rd0_ack_o, bus.rd1_ack_o);
        end
        adv();
        bus.rd0_req_i = 1'b0;
        adv();
        clear_reqs();
        adv();
    endtask

    task automatic test_random();
        int   ewcnt;
        logic err;
        logic la_w, la_0, la_1;
        logic pend, ew, e0, e1;
        do_reset();
        ewcnt = 0;
        err   = 1'b0;
        la_w  = 1'b0;
        la_0  = 1'b0;
        la_1  = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!bus.wr_req_i || la_w) begin
                bus.wr_req_i = $urandom_range(0, 99) < 55;
                bus.wr_adr_i = 6'($urandom_range(0, 63));
                bus.wr_dat_i = 13'($urandom_range(0, 8191));
            end
            if (!bus.rd0_req_i || la_0) begin
                bus.rd0_req_i = $urandom_range(0, 99) < 45;
                bus.rd0_adr_i = 6'($urandom_range(0, 63));
            end
            if (!bus.rd1_req_i || la_1) begin
                bus.rd1_req_i = $urandom_range(0, 99) < 45;
                bus.rd1_adr_i = 6'($urandom_range(0, 63));
            end
            pend = bus.rd0_req_i || bus.rd1_req_i;
            ew = 1'b0;
            e0 = 1'b0;
            e1 = 1'b0;
            if (bus.wr_req_i && !(ewcnt == WBM && pend)) ew = 1'b1;
            else if (bus.rd0_req_i && bus.rd1_req_i) begin
                if (err) e1 = 1'b1;
                else     e0 = 1'b1;
            end
            else if (bus.rd0_req_i) e0 = 1'b1;
            else if (bus.rd1_req_i) e1 = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.wr_ack_o, bus.rd0_ack_o, bus.rd1_ack_o} !== {ew, e0, e1}) begin
                errors++;
                $display("FAIL random_grant[%0d]: acks(w,r0,r1)=%b%b%b expected %b%b%b",
                         c, bus.wr_ack_o, bus.rd0_ack_o, bus.rd1_ack_o, ew, e0, e1);
            end
            if (e0 || e1) begin
                ewcnt = 0;
                err   = e0;
            end else if (!pend) begin
                ewcnt = 0;
            end else if (ew && ewcnt < WBM) begin
                ewcnt++;
            end
            la_w = bus.wr_ack_o;
            la_0 = bus.rd0_ack_o;
            la_1 = bus.rd1_ack_o;
            adv();
        end
        clear_reqs();
        adv();
    endtask

    task automatic test_drain();
        adv();
        @(negedge clk);
        checks++;
        if ((q0.size() + q1.size()) != 0) begin
            errors++;
            $display("FAIL drain: %0d reads never returned, expected 0", q0.size() + q1.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        #1;
        test_reset();
        test_write_read();
        test_alternate();
        test_burst();
        test_reset_drop();
        test_random();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ime_mv_ram_arb.md
# ime_mv_ram_arb

Single-cycle arbiter that shares the 64x13 single-port IME motion-vector RAM (`ime_mv_ram_sp_64x13`) between three requesters: the IME result writer and two readers, FME MV fetch (rd0) and MVP neighbour fetch (rd1). Each cycle it grants at most one access, drives the RAM's low-active enables, address and write data, and returns read data one cycle later tagged to the requester that issued the read. It sits between the IME/FME/MVP stage logic and the RAM instance in the ME top.

## Interface
- `WR_BURST_MAX`, 4: maximum consecutive write grants while any read is pending; legal range 1–15.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `wr_req_i`  in  1  IME write request.
- `wr_adr_i`  in  6  write address.
- `wr_dat_i`  in  13  write data.
- `wr_ack_o`  out  1  write granted this cycle.
- `rd0_req_i` / `rd1_req_i`  in  1  read requests (FME / MVP).
- `rd0_adr_i` / `rd1_adr_i`  in  6  read addresses.
- `rd0_ack_o` / `rd1_ack_o`  out  1  read granted this cycle.
- `rd0_vld_o` / `rd1_vld_o`  out  1  `rd_dat_o` holds data for that reader.
- `rd_dat_o`  out  13  read data; pass-through of `ram_rd_dat_i`.
- `ram_adr_o`  out  6  RAM address.
- `ram_wr_ena_o`  out  1  RAM write enable, low active.
- `ram_wr_dat_o`  out  13  RAM write data.
- `ram_rd_ena_o`  out  1  RAM read enable, low active.
- `ram_rd_dat_i`  in  13  RAM read data; valid the cycle after `ram_rd_ena_o` is low.

## Operation
- Requests are level signals. A requester holds `req`/`adr`/`dat` stable until it sees `ack` high. `ack` is combinational from the current requests and the arbiter state.
- At most one `ack` is high per cycle. `ram_wr_ena_o` and `ram_rd_ena_o` are never low together.
- Priority:
  - Write wins unless the burst counter `wcnt` equals `WR_BURST_MAX` and a read is pending.
  - Between readers, round-robin via pointer `rr`: 0 prefers rd0, 1 prefers rd1.
  - After a read grant, `rr` points to the other reader.
  - A lone requester always wins, whatever the `rr` value.
- Burst counter `wcnt` (4 bits):
  - Increments on a write grant while any read request is high, saturating at `WR_BURST_MAX`.
  - Clears on any read grant.
  - Clears on any cycle with no read request pending.
- Write grant drives: `ram_adr_o=wr_adr_i`, `ram_wr_dat_o=wr_dat_i`, `ram_wr_ena_o=0`, `ram_rd_ena_o=1`.
- Read grant to rdN drives: `ram_adr_o=rdN_adr_i`, `ram_rd_ena_o=0`, `ram_wr_ena_o=1`.
- No grant: both enables are 1, and `ram_adr_o`/`ram_wr_dat_o` are 0 so idle power stays low.
- Return path: registered tag `rd0_vld_q`/`rd1_vld_q` is set from the read ack of the previous cycle. `rd_dat_o=ram_rd_dat_i` unconditionally, and consumers qualify it with `vld`.
- There is no read-after-write hazard: a read granted the cycle after a write to the same address returns the new data.

## Timing
- Grant latency: 0 cycles. `ack` and the RAM controls appear in the same cycle as `req`.
- Read data latency: 1 cycle. A read ack in cycle N gives `rdN_vld_o=1` with valid `rd_dat_o` in cycle N+1.
- Throughput: one access per cycle. Back-to-back reads return data on consecutive cycles.
- Reset (`rst=1` sampled at a `clk` edge):
  - `wcnt=0`, `rr=0`, and both vld registers are 0.
  - While `rst` is high, all acks are forced to 0 and both RAM enables to 1, whatever the requests.
  - A read granted the cycle before reset asserts yields no `vld` after reset.
- Outputs while idle or in reset: acks 0, vld 0, `ram_wr_ena_o=1`, `ram_rd_ena_o=1`, `ram_adr_o=0`, `ram_wr_dat_o=0`.
- Saturation: with `WR_BURST_MAX=4`, a continuous write plus a continuous read gives the pattern W,W,W,W,R repeating.
- Simultaneous reads: rd0 and rd1 both high with no write alternate each cycle, starting with rd0 after reset.

## Test plan
- Reset, idle: hold all requests 0 → every ack/vld 0, both enables 1, `ram_adr_o=0` for all cycles.
- Write 0x1ABC to address 5, then rd0 reads address 5 the next cycle → `wr_ack_o` in cycle 0; `rd0_ack_o` in cycle 1; `rd0_vld_o=1`, `rd_dat_o=0x1ABC` in cycle 2.
- rd0 and rd1 held high for 6 cycles, no write → grants rd0,rd1,rd0,rd1,rd0,rd1; vld alternates with 1-cycle lag; the RAM address alternates between the two `adr_i` values.
- wr_req and rd1_req held high for 10 cycles, `WR_BURST_MAX=4` → grants W,W,W,W,R1,W,W,W,W,R1; never two acks in one cycle.
- rd1 granted in cycle N, `rst` asserted in cycle N+1 → `rd1_vld_o=0` in N+1 and N+2; `rr=0` after reset.
- Random traffic, 10k cycles, against a 64-entry reference model → every vld carries the model value; the two RAM enables are never low together.
